// File: rtl/frame_buffer_param.sv
// Parametrised BPP-bit frame buffer: registered read port, valid/ready write port,
// clear-screen sequencer. Define FB_DOUBLE_BUFFER_EN for front/back bank double buffering.
module frame_buffer_param #(
  parameter int unsigned     H_RES       = 800,
  parameter int unsigned     V_RES       = 480,
  parameter int unsigned     BPP         = 1,
  parameter logic [BPP-1:0]  CLEAR_VALUE = '0
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           rd_en,
  input  logic [10:0]    rd_h,
  input  logic [10:0]    rd_v,
  output logic [BPP-1:0] rd_pixel,
  output logic           rd_valid,
  input  logic           wr_valid,
  output logic           wr_ready,
  input  logic [10:0]    wr_h,
  input  logic [10:0]    wr_v,
  input  logic [BPP-1:0] wr_pixel,
  input  logic           clear_req,
  output logic           clear_busy,
  input  logic           frame_start,
  input  logic           swap_req,
  output logic           front_bank
);

  localparam int unsigned DEPTH  = H_RES * V_RES;
  localparam int unsigned ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef FB_DOUBLE_BUFFER_EN
  // Bank is the index MSB, so the array spans one full power-of-two bank plus DEPTH.
  localparam int unsigned RAM_W       = ADDR_W + 1;
  localparam int unsigned RAM_ENTRIES = (1 << ADDR_W) + DEPTH;
`else
  localparam int unsigned RAM_W       = ADDR_W;
  localparam int unsigned RAM_ENTRIES = DEPTH;
`endif
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] clr_cnt, clr_cnt_next;

  logic [ADDR_W-1:0] rd_addr, wr_addr;
  logic              rd_in_range, wr_in_range;
  logic [RAM_W-1:0]  rd_idx, wr_idx, clr_idx;
  logic              wr_fire;

  logic [BPP-1:0]    mem [RAM_ENTRIES];

  assign rd_addr     = ADDR_W'(32'(rd_v) * H_RES + 32'(rd_h));
  assign wr_addr     = ADDR_W'(32'(wr_v) * H_RES + 32'(wr_h));
  assign rd_in_range = (32'(rd_h) < H_RES) && (32'(rd_v) < V_RES);
  assign wr_in_range = (32'(wr_h) < H_RES) && (32'(wr_v) < V_RES);

  assign wr_ready   = (state == IDLE);
  assign clear_busy = (state == CLEAR);
  assign wr_fire    = wr_valid && wr_ready;

`ifdef FB_DOUBLE_BUFFER_EN
  logic front_q, swap_pending, swap_fire;

  assign swap_fire  = frame_start && swap_pending && (state != CLEAR);
  assign front_bank = front_q;
  assign rd_idx     = {front_q, rd_addr};
  assign wr_idx     = {~front_q, wr_addr};
  assign clr_idx    = {~front_q, clr_cnt};

  always_ff @(posedge clk) begin
    if (reset) begin
      front_q      <= 1'b0;
      swap_pending <= 1'b0;
    end else begin
      if (swap_fire) front_q <= ~front_q;
      swap_pending <= swap_req | (swap_pending & ~swap_fire);
    end
  end
`else
  logic unused_swap;

  assign unused_swap = ^{swap_req, frame_start};
  assign front_bank  = 1'b0;
  assign rd_idx      = rd_addr;
  assign wr_idx      = wr_addr;
  assign clr_idx     = clr_cnt;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      clr_cnt <= '0;
    end else begin
      state   <= state_next;
      clr_cnt <= clr_cnt_next;
    end
  end

  always_comb begin
    state_next   = state;
    clr_cnt_next = clr_cnt;
    case (state)
      IDLE: begin
        if (clear_req) begin
          state_next   = CLEAR;
          clr_cnt_next = '0;
        end
      end
      CLEAR: begin
        clr_cnt_next = clr_cnt + ADDR_W'(1);
        if (clr_cnt == LAST_ADDR) begin
          state_next   = IDLE;
          clr_cnt_next = '0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Reset edges commit nothing, so an aborted clear stops exactly where it was.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == CLEAR) mem[clr_idx] <= CLEAR_VALUE;
      else if (wr_fire && wr_in_range) mem[wr_idx] <= wr_pixel;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_pixel <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rd_pixel <= rd_in_range ? mem[rd_idx] : '0;
    end
  end

endmodule

// File: tb/tb_frame_buffer_param.sv
// Randomised self-checking bench for frame_buffer_param against a pixel-array reference
// model (small 16x12 geometry, 4 bpp). Follows FB_DOUBLE_BUFFER_EN if defined.
module tb_frame_buffer_param;

  localparam int unsigned H_RES = 16;
  localparam int unsigned V_RES = 12;
  localparam int unsigned BPP   = 4;
  localparam int unsigned DEPTH = H_RES * V_RES;
  localparam logic [BPP-1:0] CV = 4'h5;
`ifdef FB_DOUBLE_BUFFER_EN
  localparam bit DB = 1'b1;
`else
  localparam bit DB = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           reset, rd_en, rd_valid, wr_valid, wr_ready;
  logic [10:0]    rd_h, rd_v, wr_h, wr_v;
  logic [BPP-1:0] rd_pixel, wr_pixel;
  logic           clear_req, clear_busy, frame_start, swap_req, front_bank;

  frame_buffer_param #(
    .H_RES(H_RES), .V_RES(V_RES), .BPP(BPP), .CLEAR_VALUE(CV)
  ) dut (
    .clk(clk), .reset(reset),
    .rd_en(rd_en), .rd_h(rd_h), .rd_v(rd_v), .rd_pixel(rd_pixel), .rd_valid(rd_valid),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_h(wr_h), .wr_v(wr_v), .wr_pixel(wr_pixel),
    .clear_req(clear_req), .clear_busy(clear_busy),
    .frame_start(frame_start), .swap_req(swap_req), .front_bank(front_bank)
  );

  always #5 clk = ~clk;

  // Reference model: one pixel array per bank plus the visible control state.
  logic [BPP-1:0] m_mem [2][DEPTH];
  logic           m_front, m_pend;
  int             clr_left;
  logic [BPP-1:0] m_rd_pix;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit in_range(input int h, input int v);
    return (h < int'(H_RES)) && (v < int'(V_RES));
  endfunction

  // One clock cycle with the currently driven inputs: predict, advance, compare.
  task automatic cycle();
    logic [BPP-1:0] exp_pix;
    logic           exp_valid, busy_before, fire;
    int             back;
    busy_before = (clr_left != 0);
    back        = DB ? int'(!m_front) : 0;
    check("wr_ready", 32'(wr_ready), 32'(!busy_before));
    check("clear_busy", 32'(clear_busy), 32'(busy_before));
    check("front_bank", 32'(front_bank), 32'(m_front));
    if (reset) begin
      exp_pix   = '0;
      exp_valid = 1'b0;
    end else begin
      exp_valid = rd_en;
      if (!rd_en) exp_pix = m_rd_pix;
      else if (in_range(int'(rd_h), int'(rd_v)))
        exp_pix = m_mem[m_front][int'(rd_v) * H_RES + int'(rd_h)];
      else exp_pix = '0;
    end
    if (reset) begin
      clr_left = 0;
      m_front  = 1'b0;
      m_pend   = 1'b0;
    end else begin
      if (busy_before) begin
        m_mem[back][DEPTH - clr_left] = CV;
        clr_left--;
      end else begin
        if (wr_valid && in_range(int'(wr_h), int'(wr_v)))
          m_mem[back][int'(wr_v) * H_RES + int'(wr_h)] = wr_pixel;
        if (clear_req) clr_left = DEPTH;
      end
      if (DB) begin
        fire = frame_start && m_pend && !busy_before;
        if (fire) m_front = !m_front;
        m_pend = swap_req | (m_pend & !fire);
      end
    end
    @(posedge clk);
    #1;
    check("rd_valid", 32'(rd_valid), 32'(exp_valid));
    check("rd_pixel", 32'(rd_pixel), 32'(exp_pix));
    m_rd_pix = exp_pix;
  endtask

  task automatic wr(input int h, input int v, input int p);
    wr_valid = 1'b1; wr_h = 11'(h); wr_v = 11'(v); wr_pixel = BPP'(p);
    cycle();
    wr_valid = 1'b0;
  endtask

  task automatic rd(input int h, input int v);
    rd_en = 1'b1; rd_h = 11'(h); rd_v = 11'(v);
    cycle();
    rd_en = 1'b0;
  endtask

  task automatic pulse_swap();
    swap_req = 1'b1;    cycle(); swap_req = 1'b0;
    frame_start = 1'b1; cycle(); frame_start = 1'b0;
  endtask

  // Start a clear (caller may pre-drive a write for the same cycle) and run it out,
  // hammering the write port and re-requesting clear while busy.
  task automatic run_clear(input bit rd_during);
    int busy_cnt;
    busy_cnt  = 0;
    clear_req = 1'b1;
    cycle();
    clear_req = 1'b0;
    for (int i = 0; i < int'(DEPTH) + 2; i++) begin
      if (clear_busy) busy_cnt++;
      clear_req = (i == 50);
      wr_valid  = (i < int'(DEPTH));
      wr_h = 11'd2; wr_v = 11'd2; wr_pixel = 4'hF;
      rd_en = rd_during && ($urandom_range(0, 1) == 1);
      rd_h  = 11'($urandom_range(0, H_RES - 1));
      rd_v  = 11'($urandom_range(0, V_RES - 1));
      cycle();
    end
    wr_valid = 1'b0; rd_en = 1'b0; clear_req = 1'b0;
    check("clear_len", 32'(busy_cnt), 32'(DEPTH));
  endtask

  task automatic drain();
    for (int i = 0; i < int'(DEPTH) + 2 && clr_left != 0; i++) cycle();
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation still running at %0t, limit 2ms", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; rd_en = 1'b0; rd_h = '0; rd_v = '0;
    wr_valid = 1'b0; wr_h = '0; wr_v = '0; wr_pixel = '0;
    clear_req = 1'b0; frame_start = 1'b0; swap_req = 1'b0;
    m_front = 1'b0; m_pend = 1'b0; clr_left = 0; m_rd_pix = '0;
    for (int b = 0; b < 2; b++)
      for (int a = 0; a < int'(DEPTH); a++) m_mem[b][a] = CV;

    repeat (2) @(posedge clk);
    #1;
    check("rst_rd_pixel", 32'(rd_pixel), 32'd0);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_clear_busy", 32'(clear_busy), 32'd0);
    check("rst_wr_ready", 32'(wr_ready), 32'd1);
    check("rst_front_bank", 32'(front_bank), 32'd0);
    reset = 1'b0;

    // Bring every bank to a known state before any read.
    run_clear(1'b0);
    if (DB) begin
      pulse_swap();
      run_clear(1'b0);
    end

    // Basic write then read, range handling and aliasing.
    wr(5, 0, 1);
    rd(5, 0);
    wr(15, 11, 'hA);
    wr(0, 1, 'h3);
    rd(15, 11);
`ifndef FB_DOUBLE_BUFFER_EN
    check("rd_15_11", 32'(rd_pixel), 32'hA);
`endif
    rd(0, 1);
`ifndef FB_DOUBLE_BUFFER_EN
    check("rd_0_1", 32'(rd_pixel), 32'h3);
`endif
    rd(16, 0);
    check("rd_oor_h", 32'(rd_pixel), 32'h0);
    wr(0, 12, 'hF);
    wr(261, 0, 'hF);
    wr(16, 0, 'hF);
    rd(5, 0);
`ifndef FB_DOUBLE_BUFFER_EN
    check("oor_wr_alias_5_0", 32'(rd_pixel), 32'h1);
`endif
    rd(0, 1);
`ifndef FB_DOUBLE_BUFFER_EN
    check("oor_wr_alias_0_1", 32'(rd_pixel), 32'h3);
`endif

    // Read-first on a same-cycle collision.
    wr_valid = 1'b1; wr_h = 11'd3; wr_v = 11'd3; wr_pixel = 4'h1;
    rd_en = 1'b1; rd_h = 11'd3; rd_v = 11'd3;
    cycle();
    wr_valid = 1'b0; rd_en = 1'b0;
`ifndef FB_DOUBLE_BUFFER_EN
    check("collide_old", 32'(rd_pixel), 32'(CV));
`endif
    rd(3, 3);
`ifndef FB_DOUBLE_BUFFER_EN
    check("collide_new", 32'(rd_pixel), 32'h1);
`endif

    // Randomised traffic.
    for (int i = 0; i < 500; i++) begin
      int r;
      wr_valid = ($urandom_range(0, 1) == 1);
      wr_h = ($urandom_range(0, 15) == 0) ? 11'd261 : 11'($urandom_range(0, H_RES + 2));
      wr_v = 11'($urandom_range(0, V_RES + 1));
      wr_pixel = BPP'($urandom);
      rd_en = ($urandom_range(0, 2) != 0);
      rd_h = 11'($urandom_range(0, H_RES + 2));
      rd_v = 11'($urandom_range(0, V_RES + 1));
      clear_req = ($urandom_range(0, 199) == 0);
      reset = ($urandom_range(0, 299) == 0);
      r = int'($urandom_range(0, 9));
      swap_req = (r == 0);
      frame_start = (r == 1);
      cycle();
    end
    reset = 1'b0; wr_valid = 1'b0; rd_en = 1'b0; clear_req = 1'b0;
    swap_req = 1'b0; frame_start = 1'b0;
    drain();

    // Write accepted in the clear_req cycle, then overwritten by the clear.
    wr_valid = 1'b1; wr_h = 11'd7; wr_v = 11'd7; wr_pixel = 4'h9;
    run_clear(1'b1);
    rd(7, 7);
`ifndef FB_DOUBLE_BUFFER_EN
    check("clear_overwrites", 32'(rd_pixel), 32'(CV));
`endif

    // Reset 100 cycles into a clear.
    wr(9, 0, 'hC);
    clear_req = 1'b1;
    cycle();
    clear_req = 1'b0;
    repeat (100) cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    check("abort_busy", 32'(clear_busy), 32'd0);
    check("abort_ready", 32'(wr_ready), 32'd1);
    rd(9, 0);
    rd(0, 11);

`ifdef FB_DOUBLE_BUFFER_EN
    begin
      logic f0;
      frame_start = 1'b1; cycle(); frame_start = 1'b0;
      f0 = m_front;
      wr(1, 1, 1);
      wr(1, 1, 1);
      rd(1, 1);
      check("db_front_unchanged", 32'(front_bank), 32'(f0));
      pulse_swap();
      check("db_swapped", 32'(front_bank), 32'(!f0));
      rd(1, 1);
      check("db_rd_after_swap", 32'(rd_pixel), 32'h1);
      clear_req = 1'b1; cycle(); clear_req = 1'b0;
      pulse_swap();
      check("db_swap_deferred", 32'(front_bank), 32'(!f0));
      drain();
      check("db_still_deferred", 32'(front_bank), 32'(!f0));
      frame_start = 1'b1; cycle(); frame_start = 1'b0;
      check("db_swap_after_clear", 32'(front_bank), 32'(f0));
      rd(1, 1);
    end
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
